// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the 3-stage RISC-V core.
//   pipe_ctrl_state_t : pipeline-control state encoding
//   INST_NOP          : canonical NOP (addi x0, x0, 0) loaded on flush
//   FLUSH_CYC_DEF     : default number of flush cycles per redirect
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } pipe_ctrl_state_t;

  localparam logic [31:0] INST_NOP      = 32'h0000_0013;
  localparam int          FLUSH_CYC_DEF = 2;

endpackage

// File: rtl/gen_en_dff.sv
// gen_en_dff: enable D flip-flop bank with synchronous active-high clear.
//   i_clk : clock
//   i_rst : synchronous clear (wins over enable)
//   i_en  : load i_d on this edge
//   i_d   : data in
//   o_q   : registered data out
module gen_en_dff #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hold/flush sequencing for pc_reg, if_id and id_ex.
//   Turns EX redirect requests and EX/bus stall requests into PC load,
//   hold and flush strobes. A redirect that arrives during a bus stall is
//   parked in pend_addr and issued once the bus frees up.
// Ports:
//   clk, rst               : core clock, synchronous active-high reset
//   jump_req_i/jump_addr_i : redirect request and target from EX
//   ex_hold_i, bus_hold_i  : stall requests from EX and the bus
//   pc_jump_o/_addr_o      : load target into PC (addr is 0 when idle)
//   pc_hold_o, if_id_hold_o, id_ex_hold_o : freeze strobes
//   if_id_flush_o, id_ex_flush_o          : bubble insertion strobes
//   busy_o                 : registered, state != IDLE
//
// state | meaning
// IDLE  | no redirect in progress
// PEND  | redirect target latched, waiting for bus_hold_i to drop
// FLUSH | bubble counter running, flushes asserted
module pipe_ctrl
  import riscv_pkg::*;
#(
  parameter int FLUSH_CYC = FLUSH_CYC_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ex_hold_i,
  input  logic              bus_hold_i,
  output logic              pc_jump_o,
  output logic [ADDR_W-1:0] pc_jump_addr_o,
  output logic              pc_hold_o,
  output logic              if_id_hold_o,
  output logic              id_ex_hold_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              busy_o
);

  // The redirect cycle itself is the first flush cycle, so the counter
  // only covers the remaining FLUSH_CYC-1 cycles.
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYC - 1);
  localparam bit         MULTI    = (FLUSH_CYC > 1);

  pipe_ctrl_state_t  r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic              r_busy;
  logic [ADDR_W-1:0] w_pend_addr;
  logic              w_hold, w_jump_q, w_pend_en;
  logic              w_pc_jump, w_flush;
  logic [ADDR_W-1:0] w_jump_addr;

  assign w_hold   = ex_hold_i | bus_hold_i;
  assign w_jump_q = jump_req_i & ~ex_hold_i;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_en   = 1'b0;
    w_pc_jump   = 1'b0;
    w_jump_addr = '0;
    w_flush     = 1'b0;
    case (r_state)
      IDLE, FLUSH: begin
        w_flush = (r_state == FLUSH);
        if (w_jump_q && !bus_hold_i) begin
          w_pc_jump   = 1'b1;
          w_jump_addr = jump_addr_i;
          w_flush     = 1'b1;
          w_state_nxt = MULTI ? FLUSH : IDLE;
          w_cnt_nxt   = MULTI ? CNT_LOAD : 3'd0;
        end else if (w_jump_q) begin
          // Bus is stalled: park the target, the PC cannot take it yet.
          w_pend_en   = 1'b1;
          w_state_nxt = PEND;
          w_cnt_nxt   = 3'd0;
        end else if (r_state == FLUSH && !bus_hold_i) begin
          if (r_cnt == 3'd1) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
      end
      PEND: begin
        if (!bus_hold_i) begin
          w_pc_jump   = 1'b1;
          w_jump_addr = w_pend_addr;
          w_flush     = 1'b1;
          w_state_nxt = MULTI ? FLUSH : IDLE;
          w_cnt_nxt   = MULTI ? CNT_LOAD : 3'd0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  gen_en_dff #(.WIDTH(ADDR_W)) u_pend_addr (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_pend_en),
    .i_d   (jump_addr_i),
    .o_q   (w_pend_addr)
  );

  assign pc_jump_o      = w_pc_jump;
  assign pc_jump_addr_o = w_jump_addr;
  assign pc_hold_o      = w_hold & ~w_pc_jump;
  // A flushed register must load the bubble, so flush overrides its hold.
  assign if_id_hold_o   = w_hold & ~w_flush;
  assign id_ex_hold_o   = w_hold & ~w_flush;
  assign if_id_flush_o  = w_flush;
  assign id_ex_flush_o  = w_flush;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Three instances share the stimulus and
// differ only in FLUSH_CYC (2, 1, 3). Flag vector order:
// {pc_jump, pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, busy}
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_req = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        ex_hold = 1'b0;
  logic        bus_hold = 1'b0;

  logic        pj2, ph2, ih2, eh2, if2, ef2, b2;
  logic        pj1, ph1, ih1, eh1, if1, ef1, b1;
  logic        pj3, ph3, ih3, eh3, if3, ef3, b3;
  logic [31:0] addr2, addr1, addr3;
  logic [6:0]  flags2, flags1, flags3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        jump;
    logic [31:0] addr;
    logic        ex;
    logic        bus;
    logic        chk;
    logic [6:0]  flags;
    logic [31:0] eaddr;
  } vec_t;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYC(2), .ADDR_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
    .ex_hold_i(ex_hold), .bus_hold_i(bus_hold), .pc_jump_o(pj2),
    .pc_jump_addr_o(addr2), .pc_hold_o(ph2), .if_id_hold_o(ih2),
    .id_ex_hold_o(eh2), .if_id_flush_o(if2), .id_ex_flush_o(ef2), .busy_o(b2));

  pipe_ctrl #(.FLUSH_CYC(1), .ADDR_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
    .ex_hold_i(ex_hold), .bus_hold_i(bus_hold), .pc_jump_o(pj1),
    .pc_jump_addr_o(addr1), .pc_hold_o(ph1), .if_id_hold_o(ih1),
    .id_ex_hold_o(eh1), .if_id_flush_o(if1), .id_ex_flush_o(ef1), .busy_o(b1));

  pipe_ctrl #(.FLUSH_CYC(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
    .ex_hold_i(ex_hold), .bus_hold_i(bus_hold), .pc_jump_o(pj3),
    .pc_jump_addr_o(addr3), .pc_hold_o(ph3), .if_id_hold_o(ih3),
    .id_ex_hold_o(eh3), .if_id_flush_o(if3), .id_ex_flush_o(ef3), .busy_o(b3));

  assign flags2 = {pj2, ph2, ih2, eh2, if2, ef2, b2};
  assign flags1 = {pj1, ph1, ih1, eh1, if1, ef1, b1};
  assign flags3 = {pj3, ph3, ih3, eh3, if3, ef3, b3};

  function automatic vec_t mk(input logic r, input logic j, input logic [31:0] a,
                              input logic e, input logic b, input logic c,
                              input logic [6:0] f, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.jump = j; v.addr = a; v.ex = e; v.bus = b;
    v.chk = c; v.flags = f; v.eaddr = ea;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst       = v.rst;
    jump_req  = v.jump;
    jump_addr = v.addr;
    ex_hold   = v.ex;
    bus_hold  = v.bus;
  endtask

  task automatic settle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 7'b0, 32'h0));
    end
  endtask

  task automatic test_reset();
    vec_t v[$];
    v.push_back(mk(0, 0, 32'h0, 0, 1, 1, 7'b0111000, 32'h0));
    v.push_back(mk(0, 0, 32'h0, 1, 0, 1, 7'b0111000, 32'h0));
    v.push_back(mk(0, 0, 32'h0, 0, 0, 1, 7'b0000000, 32'h0));
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk); drive(v[i]); #1;
      checks++;
      if (flags2 !== v[i].flags || flags1 !== v[i].flags || flags3 !== v[i].flags) begin
        errors++;
        $display("FAIL reset step %0d flags %b/%b/%b required %b", i, flags2, flags1, flags3, v[i].flags);
      end
      checks++;
      if (addr2 !== 32'h0 || addr1 !== 32'h0 || addr3 !== 32'h0) begin
        errors++;
        $display("FAIL reset_addr step %0d addr %h/%h/%h required 0", i, addr2, addr1, addr3);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    vec_t v[$];
    v.push_back(mk(0, 1, 32'h100, 0, 0, 1, 7'b1000110, 32'h100));
    v.push_back(mk(1, 0, 32'h0,   0, 0, 0, 7'b0000000, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 7'b0000000, 32'h0));
    v.push_back(mk(0, 1, 32'h80,  0, 0, 1, 7'b1000110, 32'h80));
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 7'b0000111, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 7'b0000000, 32'h0));
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk); drive(v[i]); #1;
      if (v[i].chk) begin
        checks++;
        if (flags2 !== v[i].flags || addr2 !== v[i].eaddr) begin
          errors++;
          $display("FAIL reset_mid_flush step %0d got %b/%h required %b/%h", i, flags2, addr2, v[i].flags, v[i].eaddr);
        end
      end
    end
  endtask

  task automatic test_plain_jump();
    vec_t v[$];
    v.push_back(mk(0, 1, 32'h80, 0, 0, 1, 7'b1000110, 32'h80));
    v.push_back(mk(0, 0, 32'h0,  0, 0, 1, 7'b0000111, 32'h0));
    v.push_back(mk(0, 0, 32'h0,  0, 0, 1, 7'b0000000, 32'h0));
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk); drive(v[i]); #1;
      checks++;
      if (flags2 !== v[i].flags || addr2 !== v[i].eaddr) begin
        errors++;
        $display("FAIL plain_jump step %0d got %b/%h required %b/%h", i, flags2, addr2, v[i].flags, v[i].eaddr);
      end
    end
  endtask

  task automatic test_plain_jump_fc1();
    vec_t v[$];
    v.push_back(mk(0, 1, 32'h80, 0, 0, 1, 7'b1000110, 32'h80));
    v.push_back(mk(0, 0, 32'h0,  0, 0, 1, 7'b0000000, 32'h0));
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk); drive(v[i]); #1;
      checks++;
      if (flags1 !== v[i].flags || addr1 !== v[i].eaddr) begin
        errors++;
        $display("FAIL plain_jump_fc1 step %0d got %b/%h required %b/%h", i, flags1, addr1, v[i].flags, v[i].eaddr);
      end
    end
  endtask

  task automatic test_bus_stall();
    vec_t v[$];
    v.push_back(mk(0, 1, 32'h200, 0, 1, 1, 7'b0111000, 32'h0));
    v.push_back(mk(0, 1, 32'h999, 0, 1, 1, 7'b0111001, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 1, 1, 7'b0111001, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 7'b1000111, 32'h200));
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 7'b0000111, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 7'b0000000, 32'h0));
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk); drive(v[i]); #1;
      checks++;
      if (flags2 !== v[i].flags || addr2 !== v[i].eaddr) begin
        errors++;
        $display("FAIL bus_stall step %0d got %b/%h required %b/%h", i, flags2, addr2, v[i].flags, v[i].eaddr);
      end
    end
  endtask

  task automatic test_ex_hold();
    vec_t v[$];
    v.push_back(mk(0, 1, 32'h300, 1, 0, 1, 7'b0111000, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 7'b0000000, 32'h0));
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk); drive(v[i]); #1;
      checks++;
      if (flags2 !== v[i].flags || addr2 !== v[i].eaddr) begin
        errors++;
        $display("FAIL ex_hold step %0d got %b/%h required %b/%h", i, flags2, addr2, v[i].flags, v[i].eaddr);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    v.push_back(mk(0, 1, 32'h40, 0, 0, 1, 7'b1000110, 32'h40));
    v.push_back(mk(0, 1, 32'h60, 0, 0, 1, 7'b1000111, 32'h60));
    v.push_back(mk(0, 0, 32'h0,  0, 0, 1, 7'b0000111, 32'h0));
    v.push_back(mk(0, 0, 32'h0,  0, 0, 1, 7'b0000000, 32'h0));
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk); drive(v[i]); #1;
      checks++;
      if (flags2 !== v[i].flags || addr2 !== v[i].eaddr) begin
        errors++;
        $display("FAIL back_to_back step %0d got %b/%h required %b/%h", i, flags2, addr2, v[i].flags, v[i].eaddr);
      end
    end
  endtask

  task automatic test_jump_in_flush_stall();
    vec_t v[$];
    v.push_back(mk(0, 1, 32'h40, 0, 0, 1, 7'b1000110, 32'h40));
    v.push_back(mk(0, 1, 32'h70, 0, 1, 1, 7'b0100111, 32'h0));
    v.push_back(mk(0, 0, 32'h0,  0, 0, 1, 7'b1000111, 32'h70));
    v.push_back(mk(0, 0, 32'h0,  0, 0, 1, 7'b0000111, 32'h0));
    v.push_back(mk(0, 0, 32'h0,  0, 0, 1, 7'b0000000, 32'h0));
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk); drive(v[i]); #1;
      checks++;
      if (flags2 !== v[i].flags || addr2 !== v[i].eaddr) begin
        errors++;
        $display("FAIL jump_in_flush_stall step %0d got %b/%h required %b/%h", i, flags2, addr2, v[i].flags, v[i].eaddr);
      end
    end
  endtask

  task automatic test_flush_stall();
    vec_t v[$];
    v.push_back(mk(0, 1, 32'h500, 0, 0, 1, 7'b1000110, 32'h500));
    v.push_back(mk(0, 0, 32'h0,   0, 1, 1, 7'b0100111, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 1, 1, 7'b0100111, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 7'b0000111, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 7'b0000111, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 7'b0000000, 32'h0));
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk); drive(v[i]); #1;
      checks++;
      if (flags3 !== v[i].flags || addr3 !== v[i].eaddr) begin
        errors++;
        $display("FAIL flush_stall step %0d got %b/%h required %b/%h", i, flags3, addr3, v[i].flags, v[i].eaddr);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    settle();
    test_reset_mid_flush();
    settle();
    test_plain_jump();
    settle();
    test_plain_jump_fc1();
    settle();
    test_bus_stall();
    settle();
    test_ex_hold();
    settle();
    test_back_to_back();
    settle();
    test_jump_in_flush_stall();
    settle();
    test_flush_stall();
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
